// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized RV32 data memory.
// Access-size encoding, FSM states and the alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  // Only half and word accesses can be misaligned; bytes and the illegal size never are.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == MEM_H) mis = addr_lo[0];
    else if (size == MEM_W) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/dmem_sized_port_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
interface dmem_sized_port_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              resp_valid;
  logic [31:0]       read_data;
  logic              fault;
  logic              busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, write_data,
    input  req_ready, resp_valid, read_data, fault, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, write_data,
    output req_ready, resp_valid, read_data, fault, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/replicated data and
// load lane extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic        is_unsigned,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = 32'h0;
    case (size)
      MEM_B: begin
        byte_en     = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
      end
      MEM_H: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
      end
      MEM_W: begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = load_word >> {addr_lo, 3'b000};
    load_data = 32'h0;
    case (size)
      MEM_B: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      MEM_W: load_data = load_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_sized_port.sv
// RV32 byte-addressable data memory with sized accesses, fault reporting,
// registered single-cycle responses and a sequential post-reset clear.
module dmem_sized_port
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH_BYTES    = 16384,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic         clk,
  input logic         rst,
  dmem_sized_port_if.slave bus
);

  localparam int unsigned Words  = DEPTH_BYTES / 4;
  localparam int unsigned ByteAw = $clog2(DEPTH_BYTES);
  localparam int unsigned WordAw = ByteAw - 2;

  state_e            state_q, state_d;
  logic [WordAw-1:0] clear_ptr_q, clear_ptr_d;
  logic              resp_valid_q, fault_q;
  logic [31:0]       read_data_q;

  logic              accept, req_fault, out_of_range;
  logic [WordAw-1:0] req_idx, mem_idx;
  logic [3:0]        lane_be, mem_be;
  logic [31:0]       lane_wdata, mem_wdata, rd_word, load_data;
  logic [31:0]       mem [Words];

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.resp_valid = resp_valid_q;
  assign bus.fault      = fault_q;
  assign bus.read_data  = read_data_q;

  assign accept       = bus.req_valid & bus.req_ready;
  // Any address bit at or above the array size is a fault; nothing wraps.
  assign out_of_range = (bus.address >> ByteAw) != '0;
  assign req_fault    = (bus.req_size == 2'b11) | out_of_range |
                        is_misaligned(bus.req_size, bus.address[1:0]);
  assign req_idx      = bus.address[ByteAw-1:2];
  assign rd_word      = mem[req_idx];

  dmem_lane_align u_lane_align (
    .size        (bus.req_size),
    .addr_lo     (bus.address[1:0]),
    .store_data  (bus.write_data),
    .is_unsigned (bus.req_unsigned),
    .load_word   (rd_word),
    .byte_en     (lane_be),
    .store_lanes (lane_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    mem_idx     = req_idx;
    mem_be      = 4'b0000;
    mem_wdata   = lane_wdata;
    unique case (state_q)
      ST_CLEAR: begin
        mem_idx     = clear_ptr_q;
        mem_be      = 4'b1111;
        mem_wdata   = 32'h0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == WordAw'(Words - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept && bus.req_write && !req_fault) mem_be = lane_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Array has no reset so it can map onto a byte-write RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      read_data_q  <= 32'h0;
    end else begin
      resp_valid_q <= accept;
      fault_q      <= accept & req_fault;
      if (accept) read_data_q <= (bus.req_write || req_fault) ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_dmem_sized_port.sv
// Self-checking bench for dmem_sized_port: directed cases plus randomized
// traffic against a byte-array reference model.
module tb_dmem_sized_port;

  localparam int unsigned Depth = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_bad    = 0;
  logic [7:0]  ref_mem [Depth];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] obs;

  dmem_sized_port_if #(.ADDR_W(32)) bus ();

  dmem_sized_port #(
    .ADDR_W         (32),
    .DEPTH_BYTES    (Depth),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, want);
    end
  endtask

  // Reference behaviour straight from the access rules: bytes in a flat array.
  task automatic model_op(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic flt, output logic [31:0] rd);
    int unsigned nb;
    logic [31:0] val;
    flt = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= Depth);
    rd  = 32'h0;
    if (flt) return;
    nb = 1 << size;
    if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      val = 32'h0;
      for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
      if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8 * nb)) - 1);
      rd = val;
    end
  endtask

  // Issue one request and check its response one cycle later; valid stays high.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    logic        e_flt;
    logic [31:0] e_rd;
    model_op(wr, size, uns, addr, wdata, e_flt, e_rd);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.address      = addr;
    bus.write_data   = wdata;
    @(posedge clk);
    #1;
    check_val("resp_valid", 32'(bus.resp_valid), 32'h1);
    check_val("fault", 32'(bus.fault), 32'(e_flt));
    check_val("read_data", bus.read_data, e_rd);
    last_rd = e_rd;
    got = bus.read_data;
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_val("idle_fault", 32'(bus.fault), 32'h0);
    check_val("idle_read_hold", bus.read_data, last_rd);
  endtask

  // Hold reset, check reset outputs, release and measure the clear length.
  task automatic reset_and_clear();
    int cnt;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(bus.req_ready), 32'h0);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_val("rst_read_data", bus.read_data, 32'h0);
    check_val("rst_fault", 32'(bus.fault), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      if (bus.busy && !bus.req_ready) cnt++;
      else break;
      @(negedge clk);
    end
    check_val("clear_len", 32'(cnt), 32'd4096);
    check_val("ready_after_clear", 32'(bus.req_ready), 32'h1);
    check_val("busy_after_clear", 32'(bus.busy), 32'h0);
    for (int i = 0; i < Depth; i++) ref_mem[i] = 8'h0;
    last_rd = 32'h0;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.address      = 32'h0;
    bus.write_data   = 32'h0;

    reset_and_clear();
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, obs);
    check_val("lw_after_clear", obs, 32'h0);
    idle_cycle();

    // Sized loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, obs);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, obs);
    check_val("lb_0x10", obs, 32'hFFFFFFEF);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, obs);
    check_val("lbu_0x13", obs, 32'h000000DE);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, obs);
    check_val("lh_0x12", obs, 32'hFFFFDEAD);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, obs);
    check_val("lhu_0x10", obs, 32'h0000BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, obs);
    check_val("lw_0x10", obs, 32'hDEADBEEF);
    idle_cycle();

    // Partial stores merge into one word.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, obs);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, obs);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00005566, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, obs);
    check_val("lw_merged", obs, 32'h5566AA44);

    // Faults.
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, obs);
    do_req(1'b1, 2'd1, 1'b0, 32'h23, 32'hFFFF, obs);
    do_req(1'b0, 2'd0, 1'b0, 32'h4000, 32'h0, obs);
    do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, obs);
    check_val("lw_after_faults", obs, 32'h5566AA44);
    idle_cycle();

    // Store then load same address on the next cycle.
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, obs);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, obs);
    check_val("b2b_lw", obs, 32'hCAFEF00D);
    idle_cycle();

    // Randomized bursts, mostly aligned and in a small hot region.
    for (int burst = 0; burst < 40; burst++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0: a = $urandom;
          1: a = Depth - 4 + $urandom_range(0, 7);
          default: a = $urandom_range(0, 127);
        endcase
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 1);
        do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, obs);
      end
      repeat ($urandom_range(1, 2)) idle_cycle();
    end

    // Reset lands while a load is being presented.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.address      = 32'h10;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_val("midrst_busy", 32'(bus.busy), 32'h1);
    reset_and_clear();
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, obs);
    check_val("lw_after_midrst", obs, 32'h0);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
